// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: machine width, ROM
// geometry, reset PC and the fetch FSM state type.
package fetch_unit_pkg;

  localparam int          XLEN        = 32;
  localparam int          IMEM_ADDR_W = 12;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } fetch_state_t;

  // Clear the two byte-offset bits of a PC so it names a whole word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO holding fetched {pc, instruction} pairs until decode takes
// them. A synchronous clear drops every entry (used for redirects).
module fetch_skid_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [XLEN-1:0]   push_pc,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [XLEN-1:0]   head_pc,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [XLEN-1:0]   pc_q   [2];
  logic [DATA_W-1:0] data_q [2];
  logic              rd_ptr;
  logic              wr_ptr;

  // Pointer/count bookkeeping and entry writes; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: the storage is only two entries and decode sees the head even
      // when invalid, so it is reset to keep inst_pc/inst_data at zero.
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]   <= push_pc;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_pc   = pc_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch requester: owns the PC, addresses the synchronous ROM,
// captures its data one cycle later into a 2-entry skid FIFO and presents the
// FIFO head to decode over valid/ready. Execute redirects flush everything.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = IMEM_ADDR_W,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_qout,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_pc,
  output logic [DATA_W-1:0] inst_data,
  output logic              fetch_misalign
);

  fetch_state_t state;
  logic [31:0]  issue_pc;
  logic [31:0]  inflight_pc;
  logic         inflight;
  logic [1:0]   fifo_count;
  logic [1:0]   occupancy;
  logic         pop;
  logic         push;
  logic         issue;

  assign rom_addr   = issue_pc[ADDR_W+1:2];
  assign inst_valid = (fifo_count != 2'd0);
  assign pop        = inst_valid & inst_ready;
  // A redirect squashes the returning read: its data is never written.
  assign push       = inflight & ~redirect_valid;

  // Slots the FIFO will hold after this edge before any new issue lands.
  // Counting the pop that happens on this same edge keeps one fetch per
  // cycle with a 2-entry buffer and still can never overflow it.
  assign occupancy  = fifo_count - {1'b0, pop} + {1'b0, inflight};
  assign issue      = (state == ST_RUN) & fetch_en & ~redirect_valid &
                      (occupancy < 2'd2);

  // Fetch FSM, PC/in-flight tracking and the misalignment pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_BOOT;
      issue_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      fetch_misalign <= 1'b0;
    end else begin
      fetch_misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);
      unique case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  if (!fetch_en) state <= ST_STOP;
        ST_STOP: if (fetch_en)  state <= ST_RUN;
        default: state <= ST_BOOT;
      endcase
      inflight <= issue;
      if (issue) begin
        inflight_pc <= issue_pc;
      end
      if (redirect_valid) begin
        issue_pc <= word_align(redirect_pc);
      end else if (issue) begin
        issue_pc <= issue_pc + 32'd4;
      end
    end
  end

  fetch_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (push),
    .push_pc   (inflight_pc),
    .push_data (rom_qout),
    .pop       (pop),
    .head_pc   (inst_pc),
    .head_data (inst_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run, all
// scored against a stream model (accepted PCs step by 4 from the reset PC or
// the last redirect target, data = ROM word at that PC).
module tb_fetch_unit;

  localparam int          ADDR_W   = 12;
  localparam int          DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk;
  logic              rst;
  logic              fetch_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_qout;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_pc;
  logic [DATA_W-1:0] inst_data;
  logic              fetch_misalign;

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  int errors = 0;
  int checks = 0;

  // Stream model state
  logic [31:0] exp_pc;
  bit          hold_active;
  logic [31:0] held_pc;
  logic [31:0] held_data;
  bit          expect_low;
  bit          prev_redir;
  logic [31:0] prev_redir_pc;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_qout       (rom_qout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of latency.
  always @(posedge clk) rom_qout <= mem[rom_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_reset();
    exp_pc      = RESET_PC;
    hold_active = 1'b0;
    expect_low  = 1'b0;
    prev_redir  = 1'b0;
  endtask

  // One clock: score the cycle at the falling edge, then return 1 time unit
  // after the rising edge so the caller can drive the next inputs.
  task automatic tick();
    logic [31:0] word_pc;
    @(negedge clk);
    check("fifo_bound", {63'd0, dut.fifo_count > 2'd2}, 64'd0);
    check("misalign_pulse", fetch_misalign, prev_redir && (prev_redir_pc[1:0] != 2'b00));
    if (expect_low) check("flush_valid_low", inst_valid, 1'b0);
    if (hold_active) begin
      check("stall_valid", inst_valid, 1'b1);
      check("stall_pc", inst_pc, held_pc);
      check("stall_data", inst_data, held_data);
    end
    prev_redir    = redirect_valid;
    prev_redir_pc = redirect_pc;
    expect_low    = redirect_valid;
    hold_active   = 1'b0;
    if (redirect_valid) begin
      exp_pc = redirect_pc & ~32'h3;
    end else if (inst_valid && inst_ready) begin
      word_pc = exp_pc;
      check("accept_pc", inst_pc, word_pc);
      check("accept_data", inst_data, mem[word_pc[ADDR_W+1:2]]);
      exp_pc = exp_pc + 32'd4;
    end else if (inst_valid) begin
      hold_active = 1'b1;
      held_pc     = inst_pc;
      held_data   = inst_data;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    rst            = 1'b1;
    fetch_en       = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_valid", inst_valid, 1'b0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_data", inst_data, 32'h0);
    check("rst_misalign", fetch_misalign, 1'b0);
    check("rst_rom_addr", rom_addr, RESET_PC[ADDR_W+1:2]);

    // 1: boot latency and back-to-back stream
    rst = 1'b0;
    sb_reset();
    tick(); check("boot_edge_valid", inst_valid, 1'b0);
    tick(); check("e1_valid", inst_valid, 1'b0);
    tick();
    check("e2_valid", inst_valid, 1'b1);
    check("e2_pc", inst_pc, RESET_PC);
    check("e2_data", inst_data, mem[0]);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("stream_valid", inst_valid, 1'b1);
      check("stream_pc", inst_pc, RESET_PC + 32'(4 * i));
    end

    // 2: decode stall then resume
    inst_ready = 1'b0;
    repeat (5) tick();
    check("stall_count", dut.fifo_count, 2'd2);
    inst_ready = 1'b1;
    repeat (4) tick();

    // 3: redirect with a full buffer, then while streaming with a read in flight
    inst_ready = 1'b0;
    repeat (3) tick();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid_r0", inst_valid, 1'b0);
    tick(); check("redir_valid_r1", inst_valid, 1'b0);
    tick();
    check("redir_pc0", inst_pc, 32'h100);
    check("redir_data0", inst_data, mem[12'h040]);
    tick();
    check("redir_pc1", inst_pc, 32'h104);
    check("redir_data1", inst_data, mem[12'h041]);
    check("inflight_before_redir", dut.inflight, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick(); check("redir2_pc", inst_pc, 32'h200);

    // 4: misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check("misalign_hi", fetch_misalign, 1'b1);
    tick(); check("misalign_lo", fetch_misalign, 1'b0);
    tick(); check("misalign_pc", inst_pc, 32'h100);

    // 5: last ROM word, address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3FFC;
    tick();
    redirect_valid = 1'b0;
    tick(); check("wrap_rom_addr", rom_addr, 12'h000);
    tick();
    check("wrap_pc_last", inst_pc, 32'h3FFC);
    check("wrap_data_last", inst_data, mem[12'hFFF]);
    tick();
    check("wrap_pc_next", inst_pc, 32'h4000);
    check("wrap_data_next", inst_data, mem[12'h000]);

    // fetch_en low: rom_addr holds, buffer drains
    fetch_en = 1'b0;
    tick(); tick();
    check("stop_rom_addr_a", rom_addr, exp_pc[ADDR_W+1:2] + 12'(dut.fifo_count) + 12'(dut.inflight));
    repeat (3) tick();
    check("stop_drained", inst_valid, 1'b0);
    fetch_en = 1'b1;
    repeat (3) tick();
    check("resume_valid", inst_valid, 1'b1);

    // 6: asynchronous reset with a full buffer
    inst_ready = 1'b0;
    repeat (4) tick();
    check("pre_rst_count", dut.fifo_count, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", inst_valid, 1'b0);
    check("async_rst_pc", inst_pc, 32'h0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    inst_ready = 1'b1;
    sb_reset();
    tick(); tick(); tick();
    check("rst_restart_valid", inst_valid, 1'b1);
    check("rst_restart_pc", inst_pc, RESET_PC);

    // Randomized traffic scored by the stream model
    for (int n = 0; n < 800; n++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      fetch_en       = ($urandom_range(0, 7) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom_range(0, 32'h0000_FFFF);
      tick();
    end
    redirect_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
